// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters (fetch, load/store), the
// single-port memory, and the arbiter that shares it.
//   if_*    : fetch requester (read only), req/gnt handshake + read return
//   dm_*    : load/store requester, req/gnt handshake + read return
//   mem_*   : single-port memory pins (registered read data)
//   stall_* : per-requester stall flags for pipeline control
// Modports: slave = arbiter side, master = requesters + memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned DW = 32
);
  // Fetch port
  logic          if_req;
  logic [DW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  // Load/store port
  logic          dm_req;
  logic          dm_wr;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  // Memory pins
  logic          mem_cs;
  logic          mem_wr;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Pipeline stalls
  logic          stall_if;
  logic          stall_dm;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_wr, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_cs, mem_wr, mem_addr, mem_wdata,
    output stall_if, stall_dm
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_wr, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_cs, mem_wr, mem_addr, mem_wdata,
    input  stall_if, stall_dm
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF, reads only)
// and the load/store unit (DM, reads and writes). DM has priority; a streak
// counter forces an IF grant after MAX_DM_STREAK consecutive DM grants taken
// while IF was waiting. One access may issue per cycle; read data returns
// one edge after the grant with a one-cycle rvalid to the owner.
// All state changes on the falling clock edge; rst is synchronous, active high.
// Ports:
//   clk, rst : clock (falling-edge active) and synchronous reset
//   bus      : mem_port_arbiter_if.slave (requesters, memory pins, stalls)
module mem_port_arbiter #(
  parameter int unsigned DW            = 32,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_DM = 2'd2
  } state_e;

  state_e        state_q,     state_d;
  logic [SW-1:0] streak_q,    streak_d;
  logic          owner_dm_q,  owner_dm_d;
  logic          is_read_q,   is_read_d;
  logic          if_gnt_q,    if_gnt_d;
  logic          dm_gnt_q,    dm_gnt_d;
  logic          mem_cs_q,    mem_cs_d;
  logic          mem_wr_q,    mem_wr_d;
  logic [DW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          dm_rvalid_q, dm_rvalid_d;

  logic          grant_dm;
  logic          grant_if;
  logic          issued;

  // Arbitration: DM wins unless IF has waited through a full DM streak.
  always_comb begin
    grant_dm = bus.dm_req & (~bus.if_req | (streak_q < STREAK_MAX));
    grant_if = bus.if_req & ~grant_dm;
  end

  // Next-state, issue and read-return logic.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    owner_dm_d  = owner_dm_q;
    is_read_d   = is_read_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    mem_cs_d    = 1'b0;
    mem_wr_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;

    // The access issued last edge is sampled by memory now; reads answer.
    issued      = (state_q != ST_IDLE);
    if_rvalid_d = issued & is_read_q & ~owner_dm_q;
    dm_rvalid_d = issued & is_read_q &  owner_dm_q;

    if (grant_dm) begin
      state_d    = ST_GNT_DM;
      dm_gnt_d   = 1'b1;
      mem_cs_d   = 1'b1;
      mem_wr_d   = bus.dm_wr;
      mem_addr_d = bus.dm_addr;
      if (bus.dm_wr) begin
        mem_wdata_d = bus.dm_wdata;
      end
      owner_dm_d = 1'b1;
      is_read_d  = ~bus.dm_wr;
      // Streak only grows while IF is being passed over; saturates.
      if (bus.if_req && (streak_q != STREAK_MAX)) begin
        streak_d = streak_q + SW'(1);
      end
    end else if (grant_if) begin
      state_d    = ST_GNT_IF;
      if_gnt_d   = 1'b1;
      mem_cs_d   = 1'b1;
      mem_wr_d   = 1'b0;
      mem_addr_d = bus.if_addr;
      owner_dm_d = 1'b0;
      is_read_d  = 1'b1;
      streak_d   = '0;
    end else begin
      state_d    = ST_IDLE;
      is_read_d  = 1'b0;
    end
  end

  // State registers; reset drops any in-flight access so no rvalid follows.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      owner_dm_q  <= 1'b0;
      is_read_q   <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      owner_dm_q  <= owner_dm_d;
      is_read_q   <= is_read_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      mem_cs_q    <= mem_cs_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
    end
  end

  // Output drive; read data is a pass-through qualified by rvalid.
  assign bus.if_gnt    = if_gnt_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall_if  = bus.if_req & ~if_gnt_q;
  assign bus.stall_dm  = bus.dm_req & ~dm_gnt_q;

endmodule
